// File: rtl/cache_traffic_gen.sv
// Val/rdy request generator and response checker for a multi-port coherent cache:
// each port writes its pattern region, all ports meet at a barrier, then each reads back.
module cache_traffic_gen #(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned NUM_REQS    = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h00000000,
    parameter logic [31:0] PORT_STRIDE = 32'h00000100,
    parameter logic [31:0] DATA_SEED   = 32'h0a0b0c0d,
    parameter int unsigned CROSS_READ  = 1,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [NUM_PORTS*76-1:0] cachereq_msg,
    output logic [NUM_PORTS-1:0]    cachereq_val,
    input  logic [NUM_PORTS-1:0]    cachereq_rdy,
    input  logic [NUM_PORTS*44-1:0] cacheresp_msg,
    input  logic [NUM_PORTS-1:0]    cacheresp_val,
    output logic [NUM_PORTS-1:0]    cacheresp_rdy,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [NUM_PORTS*8-1:0]  err_count,
    output logic [NUM_PORTS-1:0]    timeout
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] BARRIER = 3'd3;
    localparam logic [2:0] RD_REQ  = 3'd4;
    localparam logic [2:0] RD_RESP = 3'd5;
    localparam logic [2:0] FIN     = 3'd6;

    localparam logic [1:0] TYPE_RD = 2'd0;
    localparam logic [1:0] TYPE_WR = 2'd1;

    localparam int unsigned    TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [7:0]     LAST_IDX = 8'(NUM_REQS - 1);

    function automatic logic [31:0] pattern(input logic [7:0] region, input logic [7:0] idx);
        return DATA_SEED ^ {region, 8'h00, 8'h00, idx};
    endfunction

    function automatic logic [31:0] addr_of(input logic [7:0] region, input logic [7:0] idx);
        return BASE_ADDR + (32'(region) * PORT_STRIDE) + {22'b0, idx, 2'b00};
    endfunction

    function automatic logic [75:0] mk_msg(input logic [1:0] t, input logic [7:0] opq,
                                           input logic [31:0] addr, input logic [31:0] data);
        return {t, opq, addr, 2'b00, data};
    endfunction

    logic                 busy_q, done_q, pass_q;
    logic                 start_go, all_barrier, all_fin;
    logic [NUM_PORTS-1:0] at_barrier, at_fin, err_zero;

    assign start_go    = start & ~busy_q;
    assign all_barrier = &at_barrier;
    assign all_fin     = &at_fin;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam logic [7:0] OWN = 8'(p);
        localparam logic [7:0] SRC = (CROSS_READ != 0) ? 8'((p + 1) % NUM_PORTS) : 8'(p);

        logic [2:0]    state_q, state_d;
        logic [7:0]    idx_q, idx_d;
        logic [7:0]    opq_q, opq_d;
        logic [TW-1:0] timer_q, timer_d;
        logic [75:0]   msg_q, msg_d;
        logic [7:0]    err_q, err_d;
        logic          to_q, to_d;
        logic [43:0]   resp;
        logic [7:0]    idx_nxt;
        logic          is_wr, mismatch;

        assign resp    = cacheresp_msg[p*44 +: 44];
        assign idx_nxt = idx_q + 8'd1;
        assign is_wr   = (state_q == WR_RESP);

        // msg_q holds the issued request until the next one is loaded, so it is the check reference
        assign mismatch = (resp[43:42] != msg_q[75:74]) || (resp[41:34] != msg_q[73:66]) ||
                          (resp[33:32] != 2'b00) ||
                          ((state_q == RD_RESP) && (resp[31:0] != pattern(SRC, idx_q)));

        always_comb begin
            state_d = state_q;
            idx_d   = idx_q;
            opq_d   = opq_q;
            timer_d = timer_q;
            msg_d   = msg_q;
            err_d   = err_q;
            to_d    = to_q;
            case (state_q)
                IDLE: begin
                    if (start_go) begin
                        state_d = WR_REQ;
                        idx_d   = '0;
                        opq_d   = '0;
                        timer_d = '0;
                        err_d   = '0;
                        to_d    = 1'b0;
                        msg_d   = mk_msg(TYPE_WR, 8'd0, addr_of(OWN, 8'd0), pattern(OWN, 8'd0));
                    end
                end
                WR_REQ, RD_REQ: begin
                    if (cachereq_rdy[p]) begin
                        state_d = (state_q == WR_REQ) ? WR_RESP : RD_RESP;
                        opq_d   = opq_q + 8'd1;
                        timer_d = '0;
                    end
                end
                WR_RESP, RD_RESP: begin
                    if (cacheresp_val[p]) begin
                        timer_d = '0;
                        if (mismatch && (err_q != 8'hff)) begin
                            err_d = err_q + 8'd1;
                        end
                        if (idx_q != LAST_IDX) begin
                            idx_d = idx_nxt;
                            if (is_wr) begin
                                state_d = WR_REQ;
                                msg_d   = mk_msg(TYPE_WR, opq_q, addr_of(OWN, idx_nxt),
                                                 pattern(OWN, idx_nxt));
                            end else begin
                                state_d = RD_REQ;
                                msg_d   = mk_msg(TYPE_RD, opq_q, addr_of(SRC, idx_nxt), '0);
                            end
                        end else begin
                            state_d = is_wr ? BARRIER : FIN;
                        end
                    end else if (timer_q == T_LAST) begin
                        // a write-phase timeout still parks in BARRIER so the other ports can proceed
                        to_d    = 1'b1;
                        timer_d = '0;
                        state_d = is_wr ? BARRIER : FIN;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                BARRIER: begin
                    if (all_barrier) begin
                        state_d = to_q ? FIN : RD_REQ;
                        idx_d   = '0;
                        timer_d = '0;
                        msg_d   = mk_msg(TYPE_RD, opq_q, addr_of(SRC, 8'd0), '0);
                    end
                end
                FIN: begin
                    if (all_fin) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                idx_q   <= '0;
                opq_q   <= '0;
                timer_q <= '0;
                msg_q   <= '0;
                err_q   <= '0;
                to_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                idx_q   <= idx_d;
                opq_q   <= opq_d;
                timer_q <= timer_d;
                msg_q   <= msg_d;
                err_q   <= err_d;
                to_q    <= to_d;
            end
        end

        assign cachereq_val[p]        = (state_q == WR_REQ) || (state_q == RD_REQ);
        assign cacheresp_rdy[p]       = (state_q == WR_RESP) || (state_q == RD_RESP);
        assign cachereq_msg[p*76 +: 76] = msg_q;
        assign err_count[p*8 +: 8]    = err_q;
        assign timeout[p]             = to_q;
        assign at_barrier[p]          = (state_q == BARRIER);
        assign at_fin[p]              = (state_q == FIN);
        assign err_zero[p]            = (err_q == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else if (start_go) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else if (all_fin) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (&err_zero) & ~(|timeout);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Directed bench for cache_traffic_gen: memory-model responder plus a per-port
// scoreboard of expected request messages.
module tb_cache_traffic_gen;

    localparam int NP = 2;
    localparam int NR = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [NP*76-1:0] cachereq_msg;
    logic [NP-1:0]    cachereq_val;
    logic [NP-1:0]    cachereq_rdy;
    logic [NP*44-1:0] cacheresp_msg;
    logic [NP-1:0]    cacheresp_val;
    logic [NP-1:0]    cacheresp_rdy;
    logic             busy, done, pass;
    logic [NP*8-1:0]  err_count;
    logic [NP-1:0]    timeout;

    always #5 clk = ~clk;

    cache_traffic_gen #(
        .NUM_PORTS(NP), .NUM_REQS(NR), .BASE_ADDR(32'h00000000), .PORT_STRIDE(32'h00000100),
        .DATA_SEED(32'h0a0b0c0d), .CROSS_READ(1), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cachereq_msg(cachereq_msg), .cachereq_val(cachereq_val), .cachereq_rdy(cachereq_rdy),
        .cacheresp_msg(cacheresp_msg), .cacheresp_val(cacheresp_val), .cacheresp_rdy(cacheresp_rdy),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .timeout(timeout)
    );

    int total = 0;
    int bad   = 0;

    logic [75:0] expq0[$];
    logic [75:0] expq1[$];
    logic [31:0] mem [logic [31:0]];

    bit          rsp_pend   [NP];
    logic [43:0] rsp_msg    [NP];
    int          bp_cnt     [NP];
    bit          was_xfer   [NP];
    bit          held_valid [NP];
    logic [75:0] held_msg   [NP];
    int          xfers      [NP];
    int          rdy_cycles [NP];
    logic [75:0] first_msg  [NP];

    int bad_opq_port  = -1;
    int bad_data_port = -1;
    bit drop_wr0 = 1'b0;
    bit hold_rd0 = 1'b0;
    bit hold_hit = 1'b0;

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [75:0] exp_req(input int p, input int i, input bit wr);
        int          r;
        logic [31:0] a, d;
        r = wr ? p : (p + 1) % NP;
        a = 32'(r) * 32'h100 + 32'(i) * 32'd4;
        d = wr ? (32'h0a0b0c0d ^ {8'(r), 8'h00, 16'(i)}) : 32'h0;
        return {(wr ? 2'd1 : 2'd0), (wr ? 8'(i) : 8'(NR + i)), a, 2'b00, d};
    endfunction

    // One clock: drive inputs for the coming edge from the sampled outputs, then advance.
    task automatic cycle();
        for (int p = 0; p < NP; p++) begin
            logic [75:0] m, e;
            logic [43:0] r;
            logic [31:0] a, d;
            int          sz;
            bit          send;
            m = cachereq_msg[p*76 +: 76];
            if (was_xfer[p]) chk($sformatf("val_drop_p%0d", p), cachereq_val[p], 1'b0);
            was_xfer[p] = 1'b0;
            if (cacheresp_rdy[p]) rdy_cycles[p]++;

            cacheresp_val[p] = rsp_pend[p];
            cacheresp_msg[p*44 +: 44] = rsp_pend[p] ? rsp_msg[p] : 44'h0;
            if (rsp_pend[p] && cacheresp_rdy[p]) rsp_pend[p] = 1'b0;

            if (cachereq_val[p] && held_valid[p]) chk($sformatf("bp_stable_p%0d", p), m, held_msg[p]);
            if (cachereq_val[p] && bp_cnt[p] > 0) begin
                held_msg[p]     = m;
                held_valid[p]   = 1'b1;
                cachereq_rdy[p] = 1'b0;
                bp_cnt[p]--;
            end else begin
                cachereq_rdy[p] = 1'b1;
            end

            if (cachereq_val[p] && cachereq_rdy[p]) begin
                held_valid[p] = 1'b0;
                was_xfer[p]   = 1'b1;
                xfers[p]++;
                if (xfers[p] == 1) first_msg[p] = m;
                sz = (p == 0) ? expq0.size() : expq1.size();
                chk($sformatf("req_expected_p%0d", p), (sz != 0), 1'b1);
                if (sz != 0) begin
                    e = (p == 0) ? expq0.pop_front() : expq1.pop_front();
                    chk($sformatf("req_msg_p%0d_n%0d", p, xfers[p]), m, e);
                end
                a = m[65:34];
                if (m[75:74] == 2'd1) begin
                    mem[a] = m[31:0];
                    d = 32'h0;
                end else begin
                    d = mem.exists(a) ? mem[a] : 32'hdeadbeef;
                end
                r = {m[75:74], m[73:66], 2'b00, d};
                if (p == bad_opq_port && m[73:66] == 8'h02) r[41:34] = 8'h05;
                if (p == bad_data_port && m[75:74] == 2'd0 && m[73:66] == 8'(NR + 1)) r[31:0] = r[31:0] ^ 32'h1;
                send = 1'b1;
                if (drop_wr0 && p == 0 && m[75:74] == 2'd1 && xfers[0] == 1) send = 1'b0;
                if (hold_rd0 && p == 0 && m[75:74] == 2'd0) begin
                    send     = 1'b0;
                    hold_hit = 1'b1;
                end
                if (send) begin
                    rsp_pend[p] = 1'b1;
                    rsp_msg[p]  = r;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        expq0.delete();
        expq1.delete();
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < NR; i++) begin
                if (p == 0) expq0.push_back(exp_req(p, i, 1'b1));
                else        expq1.push_back(exp_req(p, i, 1'b1));
            end
            for (int i = 0; i < NR; i++) begin
                if (p == 0) expq0.push_back(exp_req(p, i, 1'b0));
                else        expq1.push_back(exp_req(p, i, 1'b0));
            end
            xfers[p]      = 0;
            rdy_cycles[p] = 0;
            held_valid[p] = 1'b0;
            was_xfer[p]   = 1'b0;
            rsp_pend[p]   = 1'b0;
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("done_cleared", done, 1'b0);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            cycle();
            n++;
        end
        chk("run_completes", done, 1'b1);
        chk("busy_clear", busy, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_val"}, cachereq_val, '0);
        chk({tag, "_resp_rdy"}, cacheresp_rdy, '0);
        chk({tag, "_req_msg"}, cachereq_msg[75:0], '0);
        chk({tag, "_req_msg1"}, cachereq_msg[151:76], '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_pass"}, pass, 1'b0);
        chk({tag, "_err"}, err_count, '0);
        chk({tag, "_timeout"}, timeout, '0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        cachereq_rdy  = '0;
        cacheresp_val = '0;
        cacheresp_msg = '0;
        for (int p = 0; p < NP; p++) begin
            rsp_pend[p] = 1'b0; bp_cnt[p] = 0; was_xfer[p] = 1'b0; held_valid[p] = 1'b0;
            xfers[p] = 0; rdy_cycles[p] = 0; rsp_msg[p] = '0; held_msg[p] = '0; first_msg[p] = '0;
        end
        cycle();
        cycle();
        reset = 1'b0;
        chk_reset_state("reset");

        // stray response while idle must be ignored
        rsp_pend[0] = 1'b1;
        rsp_msg[0]  = {2'd1, 8'h00, 2'b00, 32'hffffffff};
        cycle();
        chk("stray_resp_rdy", cacheresp_rdy, '0);
        chk("stray_resp_held", rsp_pend[0], 1'b1);
        rsp_pend[0] = 1'b0;
        cycle();

        // basic run with a start pulse mid-run that must be ignored
        start_run();
        repeat (3) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_done(400);
        chk("basic_pass", pass, 1'b1);
        chk("basic_err", err_count, '0);
        chk("basic_timeout", timeout, '0);
        chk("basic_first_p0", first_msg[0], {2'd1, 8'h00, 32'h00000000, 2'b00, 32'h0a0b0c0d});
        chk("basic_first_p1", first_msg[1], {2'd1, 8'h00, 32'h00000100, 2'b00, 32'h0b0b0c0d});
        chk("basic_left_p0", expq0.size(), 0);
        chk("basic_left_p1", expq1.size(), 0);
        chk("basic_xfers_p0", xfers[0], 2 * NR);
        chk("basic_xfers_p1", xfers[1], 2 * NR);
        repeat (3) cycle();
        chk("done_held", done, 1'b1);
        chk("pass_held", pass, 1'b1);

        // backpressure on port 0's first request
        bp_cnt[0] = 7;
        start_run();
        wait_done(400);
        chk("bp_consumed", bp_cnt[0], 0);
        chk("bp_pass", pass, 1'b1);
        chk("bp_xfers_p0", xfers[0], 2 * NR);
        chk("bp_left_p0", expq0.size(), 0);

        // corrupted data on port 1 second read
        bad_data_port = 1;
        start_run();
        wait_done(400);
        bad_data_port = -1;
        chk("corrupt_err", err_count, 16'h0100);
        chk("corrupt_pass", pass, 1'b0);
        chk("corrupt_timeout", timeout, '0);

        // wrong opaque on port 0
        bad_opq_port = 0;
        start_run();
        wait_done(400);
        bad_opq_port = -1;
        chk("opaque_err", err_count, 16'h0001);
        chk("opaque_pass", pass, 1'b0);
        chk("opaque_left_p0", expq0.size(), 0);

        // port 0 first write never answered
        drop_wr0 = 1'b1;
        start_run();
        wait_done(400);
        drop_wr0 = 1'b0;
        chk("to_flags", timeout, 2'b01);
        chk("to_pass", pass, 1'b0);
        chk("to_err", err_count, '0);
        chk("to_wait_cycles", rdy_cycles[0], TO);
        chk("to_left_p0", expq0.size(), 2 * NR - 1);
        chk("to_left_p1", expq1.size(), 0);

        // reset while port 0 waits in RD_RESP
        hold_rd0 = 1'b1;
        hold_hit = 1'b0;
        start_run();
        n = 0;
        while (!hold_hit && n < 400) begin
            cycle();
            n++;
        end
        chk("hold_reached", hold_hit, 1'b1);
        chk("hold_in_rd_resp", cacheresp_rdy[0], 1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        hold_rd0 = 1'b0;
        for (int p = 0; p < NP; p++) rsp_pend[p] = 1'b0;
        chk_reset_state("midrun_reset");
        start_run();
        wait_done(400);
        chk("rerun_pass", pass, 1'b1);
        chk("rerun_err", err_count, '0);
        chk("rerun_timeout", timeout, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_traffic_gen.md
Name: cache_traffic_gen

Overview:
- Synthesizable, parametrised request generator and response checker for the multi-port coherent cache top.
- Replaces the hand-timed two-port stimulus with val/rdy-correct traffic on NUM_PORTS cache ports.
- Each port writes a pattern region, all ports meet at a global barrier, then each port reads back its own region or a neighbour's region (coherency check).
- Reports per-port error counts, per-port timeouts, and an aggregate pass/done.

Parameters:
NUM_PORTS, 2, number of cache ports driven (1..8)
NUM_REQS, 4, writes per port and reads per port (1..256)
BASE_ADDR, 32'h00000000, address of port 0 region
PORT_STRIDE, 32'h00000100, address offset between port regions
DATA_SEED, 32'h0a0b0c0d, write-data pattern seed
CROSS_READ, 1, 0: port p reads its own region; 1: port p reads region of port (p+1) mod NUM_PORTS
TIMEOUT, 1024, max cycles waiting for one response

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a run
cachereq_msg  out  NUM_PORTS*76  per port {type[75:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}; port p at bits [p*76 +: 76]
cachereq_val  out  NUM_PORTS  request valid
cachereq_rdy  in  NUM_PORTS  request ready
cacheresp_msg  in  NUM_PORTS*44  per port {type[43:42], opaque[41:34], len[33:32], data[31:0]}
cacheresp_val  in  NUM_PORTS  response valid
cacheresp_rdy  out  NUM_PORTS  response ready
busy  out  1  run in progress
done  out  1  run finished; held until next start or reset
pass  out  1  valid while done: all err_count zero and no timeout
err_count  out  NUM_PORTS*8  per-port saturating mismatch count
timeout  out  NUM_PORTS  per-port sticky timeout flag

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset values: cachereq_val=0, cacheresp_rdy=0, cachereq_msg=0, busy=0, done=0, pass=0, err_count=0, timeout=0. All FSMs go to IDLE and all counters clear.
- Reset mid-run aborts immediately; no request is held.
- Per-port FSM states: IDLE, WR_REQ, WR_RESP, BARRIER, RD_REQ, RD_RESP, FIN.
- IDLE -> WR_REQ on start.
  - start clears err_count, timeout, done and pass; sets busy the next cycle.
  - start while busy is ignored.
- Request i (0..NUM_REQS-1) on port p:
  - type: 1 for write, 0 for read.
  - opaque: per-port 8-bit counter, 0 at start, +1 per issued request, wraps 255->0.
  - len: 0.
  - write addr = BASE_ADDR + p*PORT_STRIDE + i*4.
  - write data = DATA_SEED ^ {p[7:0], 8'h00, i[15:0]}.
  - read addr and expected data use region q = CROSS_READ ? (p+1) mod NUM_PORTS : p, with the same formulas as writes.
  - read request data field = 0.
- Request handshake:
  - In WR_REQ/RD_REQ: cachereq_val=1, msg registered and stable.
  - Transfer when val&rdy; next cycle val=0 and state -> WR_RESP/RD_RESP.
  - At most one outstanding request per port.
- Response handshake:
  - In WR_RESP/RD_RESP: cacheresp_rdy=1; all other states drive 0.
  - Accept on val&rdy and check: type equals issued type, opaque equals issued opaque, len=0; for reads, data equals expected.
  - Any failure increments err_count[p] by 1, saturating at 255. Checks for one response count once.
  - Next state: if i<NUM_REQS-1, i++ and return to *_REQ; else WR_RESP -> BARRIER, RD_RESP -> FIN.
- Response timer:
  - Counts cycles spent in *_RESP; clears on accept.
  - Reaching TIMEOUT sets timeout[p]; the port goes to FIN (from WR_RESP it goes through BARRIER so other ports are not blocked).
- Barrier: all ports leave BARRIER together, to RD_REQ, on the cycle after the last port enters BARRIER. i and the timer reset.
- Completion: when every port is in FIN, done=1 and busy=0 the next cycle, with pass = (all err_count==0) & ~|timeout.
- A response with val arriving outside *_RESP is not accepted (rdy=0) and is not an error.
- Ports are independent except at the barrier. Simultaneous handshakes on different ports are all serviced in the same cycle.

Test Plan:
- NUM_PORTS=2, NUM_REQS=1, CROSS_READ=1, memory model with zero-wait rdy:
  - port0 writes 0x000/0x0a0b0c0d; port1 writes 0x100/0x0b0b0c0d.
  - Then port0 reads 0x100 expecting 0x0b0b0c0d; port1 reads 0x000 expecting 0x0a0b0c0d.
  - Required: done=1, pass=1.
- Backpressure: hold cachereq_rdy=0 for 7 cycles -> cachereq_val stays 1 with cachereq_msg unchanged; exactly one request transfers on the rdy cycle.
- Corrupted read data on port1, second read, NUM_REQS=4 -> err_count[1]=1, err_count[0]=0, pass=0, done=1.
- Wrong opaque returned (0x05 instead of 0x02) -> error counted once; the run still completes.
- TIMEOUT=16, port0 never responds to its first write:
  - timeout[0]=1 after 16 cycles in WR_RESP.
  - port1 passes the barrier and completes; done=1, pass=0.
- reset asserted mid-RD_RESP -> next cycle all outputs at reset values; a new start reruns cleanly with pass=1.
